awg_fifo_writer: RTL

Write-side front end for the MLAB async FIFO in the AWG output path, in the `wr_clk` domain. It accepts narrow samples over a valid/ready stream and packs `P_PACK` samples into one FIFO word. Completed words go through a one-entry hold register into the FIFO write port, with backpressure taken from the FIFO's `almost_full`/`full`. It also tracks frame boundaries, padding a partial final word and pulsing completion when the frame's last word has been written.

---
 rtl/awg_fifo_pkg.sv | 18 +
 rtl/awg_lane_packer.sv | 48 ++++
 rtl/awg_fifo_writer.sv | 95 +++++++++
 3 files changed

// File: rtl/awg_fifo_pkg.sv
// Shared types for the AWG FIFO write-side front end.
// Holds the frame FSM encoding and the lane-index sizing helper.
package awg_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    LAST_WAIT = 2'd2
  } wr_state_t;

  // Keep at least one bit so a two-lane packer still has a real counter.
  function automatic int lane_idx_wide(input int pack);
    return (pack > 2) ? $clog2(pack) : 1;
  endfunction

  localparam int LANE_IDX_WIDE = lane_idx_wide(4);

endpackage

// File: rtl/awg_lane_packer.sv
// Packs narrow samples into a FIFO-width word, lane 0 first.
// Raises a completion strobe when the top lane fills or the frame ends.
module awg_lane_packer
  import awg_fifo_pkg::*;
#(
  parameter int P_SAMPLE_WIDE = 8,
  parameter int P_PACK        = 4
) (
  input  logic                              wr_clk,
  input  logic                              rst,
  input  logic                              take,
  input  logic [P_SAMPLE_WIDE-1:0]          data,
  input  logic                              last,
  output logic                              done,
  output logic [P_SAMPLE_WIDE*P_PACK-1:0]   word
);

  localparam int LW = lane_idx_wide(P_PACK);

  logic [LW-1:0]                     lane;
  logic [P_SAMPLE_WIDE*P_PACK-1:0]   acc;

  // The accumulator is cleared on every completion, so lanes above the
  // current one are always zero and a short final word comes out padded.
  always_comb begin
    word = acc;
    for (int i = 0; i < P_PACK; i++) begin
      if (lane == LW'(i)) begin
        word[i*P_SAMPLE_WIDE +: P_SAMPLE_WIDE] = data;
      end
    end
    done = take && (last || (lane == LW'(P_PACK-1)));
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      lane <= '0;
      acc  <= '0;
    end else if (done) begin
      lane <= '0;
      acc  <= '0;
    end else if (take) begin
      lane <= lane + LW'(1);
      acc  <= word;
    end
  end

endmodule

// File: rtl/awg_fifo_writer.sv
// Write-side front end of the AWG output FIFO: sample packing, one-entry
// hold register, flag-driven backpressure, frame tracking and counters.
module awg_fifo_writer
  import awg_fifo_pkg::*;
#(
  parameter int P_SAMPLE_WIDE = 8,
  parameter int P_PACK        = 4,
  parameter int P_DATA_WIDE   = 32,
  parameter int P_CNT_WIDE    = 16
) (
  input  logic                     wr_clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [P_SAMPLE_WIDE-1:0] s_data,
  input  logic                     s_last,
  input  logic                     fifo_almost_full,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [P_DATA_WIDE-1:0]   fifo_wr_din,
  output logic [P_CNT_WIDE-1:0]    word_cnt,
  output logic [P_CNT_WIDE-1:0]    stall_cnt,
  output logic                     frame_done
);

  wr_state_t              state, state_next;
  logic                   xfer, complete, issue;
  logic                   hold_valid;
  logic [P_DATA_WIDE-1:0] hold_data, packed_word;

  // Gating with rst keeps the stale pre-reset hold word off the FIFO port.
  assign issue       = hold_valid && !fifo_almost_full && !fifo_full && !rst;
  assign xfer        = s_valid && s_ready;
  assign fifo_wr_en  = issue;
  assign fifo_wr_din = rst ? '0 : hold_data;

  awg_lane_packer #(
    .P_SAMPLE_WIDE (P_SAMPLE_WIDE),
    .P_PACK        (P_PACK)
  ) u_packer (
    .wr_clk (wr_clk),
    .rst    (rst),
    .take   (xfer),
    .data   (s_data),
    .last   (s_last),
    .done   (complete),
    .word   (packed_word)
  );

  always_comb begin
    s_ready = 1'b0;
    if (!rst && (state != LAST_WAIT)) begin
      s_ready = !hold_valid || issue;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (xfer) state_next = s_last ? LAST_WAIT : FILL;
      FILL:      if (xfer && s_last) state_next = LAST_WAIT;
      LAST_WAIT: if (issue) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Hold data is zeroed when it drains so the write port reads zero while idle.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      word_cnt   <= '0;
      stall_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= issue && (state == LAST_WAIT);
      if (complete) begin
        hold_valid <= 1'b1;
        hold_data  <= packed_word;
      end else if (issue) begin
        hold_valid <= 1'b0;
        hold_data  <= '0;
      end
      if (issue) begin
        word_cnt <= word_cnt + P_CNT_WIDE'(1);
      end
      if (hold_valid && !issue && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + P_CNT_WIDE'(1);
      end
    end
  end

endmodule
